// File: rtl/midi_voice_alloc_if.sv
// Byte-stream input and per-voice register outputs of the MIDI voice allocator.
interface midi_voice_alloc_if #(
    parameter int NUM_VOICES = 4
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                      i_valid;
    logic [7:0]                i_data;
    logic [NUM_VOICES-1:0]     o_gate;
    logic [7*NUM_VOICES-1:0]   o_note;
    logic [7*NUM_VOICES-1:0]   o_velocity;
    logic                      o_update;
    logic [VW-1:0]             o_voice;

    modport master (
        output i_valid, i_data,
        input  o_gate, o_note, o_velocity, o_update, o_voice
    );

    modport slave (
        input  i_valid, i_data,
        output o_gate, o_note, o_velocity, o_update, o_voice
    );
endinterface

// File: rtl/midi_voice_alloc.sv
// MIDI running-status parser feeding a note-on/off voice allocator with
// oldest-voice stealing; three-stage pipeline: parse, decode, allocate.
module midi_voice_alloc #(
    parameter int         NUM_VOICES = 4,
    parameter logic [3:0] CHANNEL    = 4'd0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    midi_voice_alloc_if.slave bus
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        NOSTAT = 2'd0,
        D1     = 2'd1,
        D2     = 2'd2
    } pstate_t;

    pstate_t     state_q;
    logic [7:0]  status_q;
    logic [6:0]  d1_q;
    logic        msg_valid_q;
    logic [7:0]  msg_status_q;
    logic [6:0]  msg_note_q;
    logic [6:0]  msg_vel_q;

    logic        ev_valid_q;
    logic        ev_on_q;
    logic [6:0]  ev_note_q;
    logic [6:0]  ev_vel_q;

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];
    logic [6:0]            vel_d  [NUM_VOICES];
    logic [VW-1:0]         rank_q [NUM_VOICES];
    logic [VW-1:0]         rank_d [NUM_VOICES];
    logic                  update_q, update_d;
    logic [VW-1:0]         voice_q, voice_d;

    logic                  match_s;
    logic [VW-1:0]         match_idx_s;
    logic                  free_s;
    logic [VW-1:0]         free_idx_s;
    logic [VW-1:0]         oldest_idx_s;
    logic [VW-1:0]         chosen_s;
    logic [VW-1:0]         old_rank_s;

    // Parser FSM: running status, data-byte collection, completed-message register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= NOSTAT;
            status_q     <= 8'h00;
            d1_q         <= 7'd0;
            msg_valid_q  <= 1'b0;
            msg_status_q <= 8'h00;
            msg_note_q   <= 7'd0;
            msg_vel_q    <= 7'd0;
        end else begin
            msg_valid_q <= 1'b0;
            if (bus.i_valid) begin
                if (bus.i_data[7:3] == 5'b11111) begin
                    // Real-time bytes pass through without touching parser state.
                    state_q <= state_q;
                end else if (bus.i_data[7:4] == 4'hF) begin
                    state_q  <= NOSTAT;
                    status_q <= 8'h00;
                end else if (bus.i_data[7]) begin
                    state_q  <= D1;
                    status_q <= bus.i_data;
                end else begin
                    case (state_q)
                        D1: begin
                            if ((status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD)) begin
                                state_q <= D1;
                            end else begin
                                d1_q    <= bus.i_data[6:0];
                                state_q <= D2;
                            end
                        end
                        D2: begin
                            msg_valid_q  <= 1'b1;
                            msg_status_q <= status_q;
                            msg_note_q   <= d1_q;
                            msg_vel_q    <= bus.i_data[6:0];
                            state_q      <= D1;
                        end
                        default: state_q <= NOSTAT;
                    endcase
                end
            end
        end
    end

    // Decode stage: keep only note on/off on our channel; velocity 0 means off.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ev_valid_q <= 1'b0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= 7'd0;
            ev_vel_q   <= 7'd0;
        end else begin
            ev_valid_q <= msg_valid_q && (msg_status_q[7:5] == 3'b100)
                          && (msg_status_q[3:0] == CHANNEL);
            ev_on_q    <= msg_status_q[4] && (msg_vel_q != 7'd0);
            ev_note_q  <= msg_note_q;
            ev_vel_q   <= msg_vel_q;
        end
    end

    // Voice search: held-note match, lowest free voice, oldest voice.
    always_comb begin
        match_s      = 1'b0;
        match_idx_s  = '0;
        free_s       = 1'b0;
        free_idx_s   = '0;
        oldest_idx_s = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            match_idx_s  = (gate_q[v] && (note_q[v] == ev_note_q)) ? VW'(v) : match_idx_s;
            match_s      = match_s | (gate_q[v] && (note_q[v] == ev_note_q));
            free_idx_s   = (!gate_q[v]) ? VW'(v) : free_idx_s;
            free_s       = free_s | !gate_q[v];
            oldest_idx_s = (rank_q[v] == VW'(NUM_VOICES - 1)) ? VW'(v) : oldest_idx_s;
        end
        chosen_s   = match_s ? match_idx_s : (free_s ? free_idx_s : oldest_idx_s);
        old_rank_s = rank_q[chosen_s];
    end

    // Next voice state for the pending event.
    always_comb begin
        gate_d   = gate_q;
        note_d   = note_q;
        vel_d    = vel_q;
        rank_d   = rank_q;
        update_d = 1'b0;
        voice_d  = voice_q;
        if (ev_valid_q && ev_on_q) begin
            gate_d[chosen_s] = 1'b1;
            note_d[chosen_s] = ev_note_q;
            vel_d[chosen_s]  = ev_vel_q;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VW'(v) == chosen_s) begin
                    rank_d[v] = '0;
                end else if (rank_q[v] < old_rank_s) begin
                    rank_d[v] = rank_q[v] + VW'(1);
                end else begin
                    rank_d[v] = rank_q[v];
                end
            end
            update_d = 1'b1;
            voice_d  = chosen_s;
        end else if (ev_valid_q && match_s) begin
            gate_d[match_idx_s] = 1'b0;
            update_d            = 1'b1;
            voice_d             = match_idx_s;
        end else begin
            update_d = 1'b0;
        end
    end

    // Voice registers; reset ranks make voice 0 the youngest.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gate_q   <= '0;
            update_q <= 1'b0;
            voice_q  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= 7'd0;
                vel_q[v]  <= 7'd0;
                rank_q[v] <= VW'(v);
            end
        end else begin
            gate_q   <= gate_d;
            note_q   <= note_d;
            vel_q    <= vel_d;
            rank_q   <= rank_d;
            update_q <= update_d;
            voice_q  <= voice_d;
        end
    end

    assign bus.o_gate   = gate_q;
    assign bus.o_update = update_q;
    assign bus.o_voice  = voice_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign bus.o_note[7*g +: 7]     = note_q[g];
        assign bus.o_velocity[7*g +: 7] = vel_q[g];
    end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed and random byte streams checked against an age-list voice model.
module tb_midi_voice_alloc;
    localparam int NV = 4;
    localparam int CH = 0;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    midi_voice_alloc_if #(.NUM_VOICES(NV)) bus ();

    midi_voice_alloc #(.NUM_VOICES(NV), .CHANNEL(4'd0)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: voice registers plus an age list, youngest first.
    int m_gate [NV];
    int m_note [NV];
    int m_vel  [NV];
    int age    [$];
    int m_state;
    int m_stat;
    int m_d1;
    int exp_q  [$];
    int got_q  [$];

    always @(negedge clk) begin
        if (!rst && bus.o_update === 1'b1) got_q.push_back(int'(bus.o_voice));
    end

    function automatic void model_reset();
        age.delete();
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 0; m_note[v] = 0; m_vel[v] = 0;
            age.push_back(v);
        end
        m_state = 0; m_stat = 0; m_d1 = 0;
        exp_q.delete();
    endfunction

    function automatic void model_on(int n, int vel);
        int c;
        int pos;
        c = -1;
        for (int v = 0; v < NV; v++) if (m_gate[v] != 0 && m_note[v] == n) c = v;
        if (c < 0) for (int v = NV - 1; v >= 0; v--) if (m_gate[v] == 0) c = v;
        if (c < 0) c = age[NV-1];
        m_gate[c] = 1; m_note[c] = n; m_vel[c] = vel;
        pos = 0;
        for (int i = 0; i < age.size(); i++) if (age[i] == c) pos = i;
        age.delete(pos);
        age.push_front(c);
        exp_q.push_back(c);
    endfunction

    function automatic void model_off(int n);
        for (int v = 0; v < NV; v++) begin
            if (m_gate[v] != 0 && m_note[v] == n) begin
                m_gate[v] = 0;
                exp_q.push_back(v);
            end
        end
    endfunction

    function automatic void model_byte(int b);
        int hi;
        if (b >= 'hF8) begin
        end else if (b >= 'hF0) begin
            m_state = 0; m_stat = 0;
        end else if (b >= 'h80) begin
            m_stat = b; m_state = 1;
        end else if (m_state == 1) begin
            hi = m_stat >> 4;
            if (hi != 'hC && hi != 'hD) begin
                m_d1 = b; m_state = 2;
            end
        end else if (m_state == 2) begin
            m_state = 1;
            hi = m_stat >> 4;
            if ((m_stat & 15) == CH) begin
                if (hi == 9 && b != 0) model_on(m_d1, b);
                else if (hi == 8 || hi == 9) model_off(m_d1);
            end
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(int b);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'(b);
        model_byte(b);
        @(posedge clk);
    endtask

    task automatic idle(int n);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        got_q.delete();
    endtask

    task automatic check(string tag);
        int n;
        logic [NV-1:0] g;
        idle(4);
        for (int v = 0; v < NV; v++) g[v] = (m_gate[v] != 0);
        chk($sformatf("%s gate", tag), 32'(bus.o_gate), 32'(g));
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("%s note%0d", tag, v), 32'(bus.o_note[7*v +: 7]), 32'(m_note[v]));
            chk($sformatf("%s vel%0d", tag, v), 32'(bus.o_velocity[7*v +: 7]), 32'(m_vel[v]));
        end
        chk($sformatf("%s nupd", tag), 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s upd%0d voice", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int r;
        int st;
        vectors     = 0;
        miscompares = 0;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        rst         = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst gate", 32'(bus.o_gate), 32'h0);
        chk("rst note", 32'(bus.o_note), 32'h0);
        chk("rst vel", 32'(bus.o_velocity), 32'h0);
        chk("rst update", 32'(bus.o_update), 32'h0);
        chk("rst voice", 32'(bus.o_voice), 32'h0);

        // Basic note on with pipeline latency.
        send('h90); send('h3C); send('h64);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("lat k", 32'(bus.o_update), 32'h0);
        @(negedge clk);
        chk("lat k+1", 32'(bus.o_update), 32'h0);
        @(negedge clk);
        chk("lat k+2", 32'(bus.o_update), 32'h1);
        chk("lat voice", 32'(bus.o_voice), 32'h0);
        check("basic");
        chk("basic gate", 32'(bus.o_gate), 32'h1);
        chk("basic note", 32'(bus.o_note[6:0]), 32'h3C);

        send('h40); send('h50);
        check("running");
        send('h3C); send('h00);
        check("vel0 off");
        chk("vel0 gate", 32'(bus.o_gate), 32'h2);

        send('h80); send('h40); send('h00);
        send('h90);
        for (int n = 'h30; n <= 'h34; n++) begin send(n); send('h7F); end
        check("steal");
        chk("steal note0", 32'(bus.o_note[6:0]), 32'h34);
        chk("steal gate", 32'(bus.o_gate), 32'hF);
        send('h35); send('h7F);
        check("steal2");
        chk("steal2 note1", 32'(bus.o_note[13:7]), 32'h35);

        send('h91); send('h3C); send('h64);
        send('hC0); send('h05); send('h3C); send('h64);
        send('hB0); send('h07); send('h7F);
        check("filter");

        do_reset();
        send('h90); send('hF8); send('h3C); send('hFE); send('h64);
        check("realtime");
        send('hF0); send('h3D); send('h64);
        check("syscommon");
        send('h90); send('h3C); send('h64); send('h3D); send('h64);
        check("b2b");
        send('h90); send('h3C); send('h20);
        check("retrig");
        chk("retrig vel0", 32'(bus.o_velocity[6:0]), 32'h20);

        send('h90); send('h3C);
        do_reset();
        send('h64); send('h3C); send('h64);
        check("rst mid");
        chk("rst mid gate", 32'(bus.o_gate), 32'h0);

        // Random message mix: mostly note traffic on a small note range.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                st = ($urandom_range(0, 2) == 0) ? 'h80 : 'h90;
                st = st | (($urandom_range(0, 5) == 0) ? 1 : 0);
                if ($urandom_range(0, 1) == 0 || m_stat != st) send(st);
                send('h30 + $urandom_range(0, 7));
                if ($urandom_range(0, 5) == 0) send('hF8);
                send(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127));
            end else if (r == 6) begin
                send('hC0); send($urandom_range(0, 127));
            end else if (r == 7) begin
                send('hF2); send($urandom_range(0, 127));
            end else if (r == 8) begin
                send('hF8 + $urandom_range(0, 7));
            end else begin
                send($urandom_range(0, 127));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
            if (it % 15 == 14) check($sformatf("rand%0d", it));
            if (it == 150) begin
                check("pre rst");
                do_reset();
            end
        end
        check("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/midi_voice_alloc.md
# midi_voice_alloc

Parses the raw MIDI byte stream from the MIDI receiver and owns the synth's pool of oscillator voices. It turns Note On and Note Off messages on one channel into per-voice gate, note and velocity registers. When every voice is busy, it steals the oldest one. It sits between the MIDI receiver's byte/strobe output and the voice oscillators, which read these registers directly and replace the fixed test-tone FCW.

## Interface
- NUM_VOICES, default 4: size of the voice pool, 2..8.
- CHANNEL, default 4'd0: MIDI channel accepted, 0..15.
- i_clk  in  1: system clock, the same clock as the MIDI receiver and the audio core.
- i_rst  in  1: reset, asynchronous, active-high.
- i_valid  in  1: one-cycle strobe; i_data is valid.
- i_data  in  8: received MIDI byte.
- o_gate  out  NUM_VOICES: bit v is 1 while voice v holds a note.
- o_note  out  7*NUM_VOICES: voice v note is at [7v+6:7v].
- o_velocity  out  7*NUM_VOICES: voice v velocity is at [7v+6:7v].
- o_update  out  1: one-cycle pulse when a voice register changes.
- o_voice  out  $clog2(NUM_VOICES): index of the voice changed, valid with o_update.

## Operation
- Parser states:
  - NOSTAT: no running status.
  - D1: waiting for the first data byte.
  - D2: waiting for the second data byte.
- Bytes are classified only when i_valid=1.
- Status bytes 0x80–0xEF:
  - Latch the byte as running status.
  - Go to D1.
  - Abandon any partial message.
- System common bytes 0xF0–0xF7: clear running status and go to NOSTAT.
- Real-time bytes 0xF8–0xFF: ignored completely; state and partial data are unchanged.
- Data bytes (bit7=0):
  - NOSTAT: drop the byte.
  - D1, status 0xC/0xD: message complete (one data byte). Discard it and stay in D1.
  - D1, other status: store the byte as d1 and go to D2.
  - D2: message complete. Return to D1, keeping running status.
- Accepted messages:
  - A message is accepted only for status 0x8n or 0x9n with n==CHANNEL. All others are consumed and discarded.
  - 0x9n with velocity 0 is treated as Note Off.
- Note On (note N, velocity V):
  - Retrigger: if any voice has gate=1 and note=N, update that voice.
  - Otherwise, use the lowest-index voice with gate=0.
  - Otherwise, steal the voice with age rank NUM_VOICES-1 (the oldest).
  - The chosen voice gets gate=1, note=N, velocity=V.
  - The chosen voice's rank becomes 0. Every voice whose rank was below the chosen voice's old rank increments by 1.
  - Ranks always form a permutation of 0..NUM_VOICES-1.
- Note Off (note N):
  - The voice with gate=1 and note=N gets gate=0. Its note, velocity and rank are kept.
  - If no voice matches, nothing changes and o_update does not pulse.
  - The retrigger rule guarantees at most one voice matches.
- o_update/o_voice pulse once per change, including retriggers and steals.

## Timing
- Reset values:
  - All outputs 0 (o_gate, o_note, o_velocity, o_update, o_voice).
  - Parser in NOSTAT.
  - Rank of voice v = v.
- Latency:
  - Edge k samples the final data byte.
  - Edge k+1 registers the decoded event.
  - Edge k+2 updates the voice registers and asserts o_update for the cycle after edge k+2.
- Throughput:
  - i_valid may be high on every cycle.
  - Events are at least 2 bytes apart, so allocation never stalls and no bytes are lost.
- A new event never sees stale state: allocation uses the registers as updated by the previous event.
- Reset mid-message:
  - Partial data is discarded.
  - A data byte after reset is dropped (NOSTAT).
  - A pending event in the pipeline is cancelled.

## Test plan
- Basic Note On:
  - Stimulus: 0x90,0x3C,0x64.
  - Response: o_gate=0001, voice0 note=0x3C, velocity=0x64. o_update=1 with o_voice=0, two cycles after the last byte.
- Running status and velocity-0 Note Off:
  - Stimulus: 0x90,0x3C,0x64,0x40,0x50, then 0x3C,0x00.
  - Response: voice1 has note=0x40, velocity=0x50. Then o_gate=0010, with an o_update for voice 0.
- Voice stealing:
  - Stimulus: Note Ons 0x30,0x31,0x32,0x33,0x34, all with velocity 0x7F.
  - Response: 0x34 lands on voice0. Voices 1–3 keep 0x31–0x33. o_gate=1111.
  - Follow-up: Note On 0x35 lands on voice1.
- Channel and message filtering:
  - Stimulus: 0x91,0x3C,0x64.
  - Response: no update.
  - Stimulus: 0xC0,0x05,0x3C,0x64.
  - Response: no update (program change with running status consumes each byte singly).
  - Stimulus: 0xB0,0x07,0x7F.
  - Response: no update.
- Interleaved system bytes:
  - Stimulus: 0x90,0xF8,0x3C,0xFE,0x64.
  - Response: voice0 has note=0x3C.
  - Stimulus: then 0xF0,0x3D,0x64.
  - Response: ignored.
  - Stimulus: back-to-back i_valid for 0x90,0x3C,0x64,0x3D,0x64.
  - Response: two updates, on voices 0 and 1.
- Reset mid-message:
  - Stimulus: 0x90,0x3C; pulse i_rst; then 0x64,0x3C,0x64.
  - Response: outputs stay 0 and no o_update.
  - Also: a retrigger of an active note 0x3C with velocity 0x20 updates the same voice's velocity only.
